// File: rtl/wts_pkg.sv
// Shared types, constants and address helper for the wave table read engine.
package wts_pkg;

  localparam int unsigned WAVE_LEN       = 32;
  localparam int unsigned WAVE_NUM       = 24;
  localparam int unsigned RAM_DEPTH      = 768;
  localparam int unsigned CH_NUM_DEFAULT = 6;

  typedef logic [11:0] freq_t;
  typedef logic [4:0]  ptr_t;
  typedef logic [4:0]  wave_t;
  typedef logic [9:0]  addr_t;
  typedef logic [7:0]  data_t;

  // Tag that travels alongside a read through the RAM pipeline.
  typedef struct packed {
    logic       valid;
    logic       mute;
    logic [2:0] ch;
  } rd_tag_t;

  // Compose a sample address; out-of-range waveform selects clamp to the last table.
  function automatic addr_t wave_addr(input wave_t wave, input ptr_t ptr);
    wave_t w;
    w = (wave >= wave_t'(WAVE_NUM)) ? wave_t'(WAVE_NUM - 1) : wave;
    return {w, ptr};
  endfunction

endpackage

// File: rtl/wts_wave_reader_if.sv
// Sound RAM port: the reader drives address/write, the RAM returns registered data.
interface wts_wave_reader_if;

  logic           sram_we;
  wts_pkg::addr_t sram_a;
  wts_pkg::data_t sram_d;
  wts_pkg::data_t sram_q;

  modport master (output sram_we, output sram_a, output sram_d, input sram_q);
  modport slave  (input sram_we, input sram_a, input sram_d, output sram_q);

endinterface

// File: rtl/wts_channel_phase.sv
// Per-channel phase state: period down counter and wrapping sample pointer.
module wts_channel_phase
  import wts_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  logic  key_on,
  input  freq_t freq,
  output ptr_t  ptr
);

  freq_t cnt;

  // Advance only in this channel's slot; key off parks the pointer at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      ptr <= '0;
    end else if (en) begin
      if (!key_on) begin
        ptr <= '0;
        cnt <= freq;
      end else if (cnt == '0) begin
        cnt <= freq;
        ptr <= ptr + 5'd1;
      end else begin
        cnt <= cnt - 12'd1;
      end
    end
  end

endmodule

// File: rtl/wts_wave_reader.sv
// Time-division wave table reader: one slot per clock, CH_NUM channel reads
// followed by one CPU write slot per frame, samples tagged with their channel.
module wts_wave_reader
  import wts_pkg::*;
#(
  parameter int unsigned CH_NUM = CH_NUM_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CH_NUM-1:0]      ch_key_on,
  input  logic [CH_NUM*12-1:0]   ch_freq,
  input  logic [CH_NUM*5-1:0]    ch_wave,
  input  logic                   cpu_we,
  input  logic [9:0]             cpu_a,
  input  logic [7:0]             cpu_d,
  output logic                   cpu_busy,
  wts_wave_reader_if.master      sram,
  output logic [7:0]             sample_q,
  output logic [2:0]             sample_ch,
  output logic                   sample_valid
);

  localparam int unsigned SLOT_W = $clog2(CH_NUM + 1);
  typedef logic [SLOT_W-1:0] slot_t;
  localparam slot_t CPU_SLOT = slot_t'(CH_NUM);

  slot_t   slot;
  ptr_t    ch_ptr [CH_NUM];
  addr_t   cpu_addr;
  data_t   cpu_data;
  logic    chan_slot;
  wave_t   cur_wave;
  ptr_t    cur_ptr;
  logic    cur_key;
  rd_tag_t tag1;
  rd_tag_t tag2;

  // Slot schedule: 0..CH_NUM-1 are channel reads, CH_NUM is the CPU slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) slot <= '0;
    else       slot <= (slot == CPU_SLOT) ? '0 : slot + slot_t'(1);
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_phase
    wts_channel_phase u_phase (
      .clk    (clk),
      .reset  (reset),
      .en     (slot == slot_t'(c)),
      .key_on (ch_key_on[c]),
      .freq   (ch_freq[c*12 +: 12]),
      .ptr    (ch_ptr[c])
    );
  end

  // Select the active channel's controls and pre-update pointer.
  always_comb begin
    chan_slot = (slot != CPU_SLOT);
    cur_wave  = '0;
    cur_ptr   = '0;
    cur_key   = 1'b0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      if (slot == slot_t'(c)) begin
        cur_wave = ch_wave[c*5 +: 5];
        cur_ptr  = ch_ptr[c];
        cur_key  = ch_key_on[c];
      end
    end
  end

  // RAM port and CPU write capture; a request is only accepted while idle,
  // so capture and CPU-slot retirement never coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram.sram_we <= 1'b0;
      sram.sram_a  <= '0;
      sram.sram_d  <= '0;
      cpu_busy     <= 1'b0;
      cpu_addr     <= '0;
      cpu_data     <= '0;
    end else begin
      sram.sram_we <= 1'b0;
      if (chan_slot) begin
        sram.sram_a <= wave_addr(cur_wave, cur_ptr);
      end else if (cpu_busy) begin
        sram.sram_we <= (cpu_addr < addr_t'(RAM_DEPTH));
        sram.sram_a  <= cpu_addr;
        sram.sram_d  <= cpu_data;
      end
      if (!cpu_busy && cpu_we) begin
        cpu_addr <= cpu_a;
        cpu_data <= cpu_d;
        cpu_busy <= 1'b1;
      end else if (!chan_slot && cpu_busy) begin
        cpu_busy <= 1'b0;
      end
    end
  end

  // Tag pipeline aligned with the registered address and registered RAM data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag1         <= '0;
      tag2         <= '0;
      sample_valid <= 1'b0;
      sample_q     <= '0;
      sample_ch    <= '0;
    end else begin
      tag1         <= '{valid: chan_slot, mute: !cur_key, ch: 3'(slot)};
      tag2         <= tag1;
      sample_valid <= tag2.valid;
      if (tag2.valid) begin
        sample_ch <= tag2.ch;
        sample_q  <= tag2.mute ? '0 : sram.sram_q;
      end
    end
  end

endmodule

// File: doc/wts_wave_reader.md
# wts_wave_reader

Time-division read engine for the wave table sound RAM. It steps through a fixed slot schedule, one slot per clock. Each channel slot advances that channel's phase and issues a read of the channel's current waveform sample. The final slot of each frame is reserved for a pending CPU write. It owns the RAM port (`sram_we`/`sram_a`/`sram_d`/`sram_q`) and delivers one tagged 8-bit sample per channel per frame to the mixer.

## Interface
- `CH_NUM`, 6: number of channels; the frame is `CH_NUM+1` cycles long.
- `clk`  in  1: single clock for the whole block.
- `reset`  in  1: asynchronous, active-high reset.
- `ch_key_on`  in  CH_NUM: per-channel key on.
- `ch_freq`  in  CH_NUM*12: per-channel 12-bit period; channel c uses bits [c*12+11:c*12].
- `ch_wave`  in  CH_NUM*5: per-channel waveform select, 0..23.
- `cpu_we`  in  1: CPU write request.
- `cpu_a`  in  10: CPU write address.
- `cpu_d`  in  8: CPU write data.
- `cpu_busy`  out  1: a captured write is pending.
- `sram_we`  out  1: RAM write enable.
- `sram_a`  out  10: RAM address.
- `sram_d`  out  8: RAM write data.
- `sram_q`  in  8: RAM read data; registered, valid the cycle after a read.
- `sample_q`  out  8: sample value.
- `sample_ch`  out  3: channel index that `sample_q` belongs to.
- `sample_valid`  out  1: one-cycle strobe; `sample_q` and `sample_ch` are valid.

## Operation
- **Slot counter** `slot`, range 0..CH_NUM:
  - Slots 0..CH_NUM-1 are channel slots; slot CH_NUM is the CPU slot.
  - Increments every cycle and wraps CH_NUM→0.
- **Per-channel state:** 12-bit down counter `cnt`, 5-bit sample pointer `ptr`.
- **Channel slot c, key on:**
  - If `cnt==0`: load `cnt` with `ch_freq[c]` and set `ptr <= ptr+1`. `ptr` wraps 31→0.
  - Otherwise `cnt <= cnt-1`.
  - Resulting sample period is `(ch_freq+1)*(CH_NUM+1)` clocks. With `freq=0` the pointer advances every frame.
  - A `ch_freq` change takes effect at the next reload.
- **Channel slot c, key off:** `ptr <= 0`, `cnt <= ch_freq[c]`. The sample is still read, but `sample_q` is forced to 0.
- **Read address:** `sram_a = wave*32 + ptr`, where `wave = min(ch_wave[c], 23)`. Values 24..31 clamp to 23 (base 736). Reads use the pre-update `ptr`.
- **CPU capture:**
  - When `cpu_busy==0` and `cpu_we==1`, latch `cpu_a`/`cpu_d` and set `cpu_busy`.
  - `cpu_we` while busy is ignored; the requester waits for busy low.
- **CPU slot:**
  - If busy and latched address < 768: `sram_we=1`, `sram_a`/`sram_d` = latched values.
  - If busy and latched address ≥ 768: the write is dropped with no `sram_we`.
  - In both busy cases, `cpu_busy` clears at the end of the slot.
  - If not busy: idle, `sram_we=0`, and no sample is produced.
- **Simultaneous events:** a request arriving in the same cycle the CPU slot starts is captured that cycle. It is written at the next CPU slot, not the current one.

## Timing
- All outputs are registered.
- **Reset values:** `sram_we=0`, `sram_a=0`, `sram_d=0`, `sample_q=0`, `sample_ch=0`, `sample_valid=0`, `cpu_busy=0`. Internal state resets to `slot=0` and all `cnt`/`ptr`=0.
- **Read pipeline, slot decision made in cycle k:**
  - `sram_a` is valid in cycle k+1.
  - `sram_q` is valid in cycle k+2.
  - `sample_q`/`sample_ch`/`sample_valid` are valid in cycle k+3.
- `sample_valid` pulses CH_NUM times per frame, in channel order 0..CH_NUM-1, with a one-cycle gap after the CPU slot.
- A write appears on `sram_we` one cycle after its CPU-slot decision. `cpu_busy` falls in the same cycle.
- **Worst-case CPU latency:** capture to `cpu_busy` low is CH_NUM+2 cycles.
- **Reset mid-operation:** the pending write is discarded and the in-flight pipeline is flushed, so no `sample_valid` appears after reset until 3 cycles after release.

## Structure
- **Package `wts_pkg`:**
  - `WAVE_LEN=32`, `WAVE_NUM=24`, `RAM_DEPTH=768`, default `CH_NUM=6`.
  - 12-bit freq type, 5-bit ptr type, and the address compose/clamp function.
- **Sub-module `wts_channel_phase`:**
  - Contains `cnt`/`ptr`, key-off reload and wrap logic.
  - Instantiated CH_NUM times, with a per-instance enable when `slot==c`.
- The top level holds the slot counter, address mux, CPU capture, and output pipeline.

## Test plan
- **Reset, then idle:** all outputs 0, then `sample_valid` every channel slot with `sample_q=0` (all keyed off).
- **Ch0 on, freq=0, wave=2:** ch0 reads 0x040, 0x041, 0x042… in consecutive frames. Ch0 at `ptr=31` is followed by 0x040.
- **Ch1 on, freq=3:** `sram_a` for ch1 advances once every 4 frames (28 clocks).
- **Write 0x5A to 0x041 while ch0 reads wave 2:** `sram_we` fires only in the CPU slot. A later ch0 sample at `ptr=1` returns 0x5A.
- **Clamp and drop:** ch2 `wave=30` reads base 0x2E0. A write to address 800 produces no `sram_we`, and `cpu_busy` still clears.
- **Reset mid-write:**
  - Assert `reset` while `cpu_busy=1`: no write occurs and `cpu_busy=0`.
  - After release, the first `sample_valid` appears at cycle 3.
